clken_nco: RTL and testbench

CLKEN_NCO -- requirements
Module: clken_nco

---
 rtl/clken_nco_pkg.sv | 27 ++
 rtl/clken_nco_if.sv | 20 ++
 rtl/clken_nco_ch.sv | 68 ++++++
 rtl/clken_nco.sv | 57 +++++
 tb/tb_clken_nco.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/clken_nco_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clken_pkg
// Description : Shared defaults, channel-index width helper and test constants
//               for the clock-enable NCO.
// Revision    : 1.0 - initial release
// ============================================================================
package clken_pkg;

    localparam int c_DEF_NCH   = 4;
    localparam int c_DEF_ACC_W = 24;

    // Increments used by the verification scenarios (ACC_W = 8).
    localparam int c_TEST_INC_QUARTER = 64;
    localparam int c_TEST_INC_SLOW    = 32;
    localparam int c_TEST_INC_HALF    = 128;
    localparam int c_TEST_INC_3       = 3;
    localparam int c_TEST_INC_5       = 5;
    localparam int c_TEST_INC_MAX     = 255;

    // Channel index width; a single channel still needs one select bit.
    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clken_nco_if.sv
`default_nettype none
// ============================================================================
// Module      : clken_nco_if
// Description : Configuration command handshake between host and NCO bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface clken_nco_if #(
    parameter int CH_W  = 2,
    parameter int ACC_W = 24
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_sync;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_inc;

    modport master (output cfg_valid, cfg_sync, cfg_ch, cfg_inc, input cfg_ready);
    modport slave  (input cfg_valid, cfg_sync, cfg_ch, cfg_inc, output cfg_ready);
endinterface
`default_nettype wire

// File: rtl/clken_nco_ch.sv
`default_nettype none
// ============================================================================
// Module      : clken_nco_ch
// Description : One NCO channel: accumulator, active and pending increment,
//               carry-driven registered clock-enable pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module clken_nco_ch #(
    parameter int ACC_W = 24
) (
    input  wire logic             clock,
    input  wire logic             resetn,
    input  wire logic             i_sync,
    input  wire logic             i_wr,
    input  wire logic [ACC_W-1:0] i_wr_inc,
    output logic                  o_en,
    output logic                  o_pend
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_pnd_val;
    logic             r_pend;
    logic             r_en;

    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic             w_apply;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry = w_sum[ACC_W];
    // Swap the increment only at a wrap so no pulse interval is ever shortened;
    // a stopped channel has no wrap to wait for.
    assign w_apply = r_pend & (w_carry | (r_inc == '0));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_acc     <= '0;
            r_inc     <= '0;
            r_pnd_val <= '0;
            r_pend    <= 1'b0;
            r_en      <= 1'b0;
        end else if (i_sync) begin
            r_acc  <= '0;
            r_en   <= 1'b0;
            r_pend <= 1'b0;
            if (r_pend) begin
                r_inc <= r_pnd_val;
            end
        end else begin
            r_acc <= w_sum[ACC_W-1:0];
            r_en  <= w_carry;
            if (w_apply) begin
                r_inc  <= r_pnd_val;
                r_pend <= 1'b0;
            end
            if (i_wr) begin
                r_pnd_val <= i_wr_inc;
                r_pend    <= 1'b1;
            end
        end
    end

    assign o_en   = r_en;
    assign o_pend = r_pend;

endmodule
`default_nettype wire

// File: rtl/clken_nco.sv
`default_nettype none
// ============================================================================
// Module      : clken_nco
// Description : Bank of NCH clock-enable NCOs with a shared config handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module clken_nco
    import clken_pkg::*;
#(
    parameter int NCH   = c_DEF_NCH,
    parameter int ACC_W = c_DEF_ACC_W,
    parameter int CH_W  = ch_idx_w(NCH)
) (
    input  wire logic     clock,
    input  wire logic     resetn,
    clken_nco_if.slave    cfg,
    output logic [NCH-1:0] en_out,
    output logic [NCH-1:0] pend
);

    logic           w_hs;
    logic           w_pend_sel;
    logic [NCH-1:0] w_wr;

    // Out-of-range channels select nothing, so they read as not pending.
    always_comb begin
        w_pend_sel = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                w_pend_sel = pend[i];
            end
        end
    end

    assign cfg.cfg_ready = cfg.cfg_sync | ~w_pend_sel;
    assign w_hs          = cfg.cfg_valid & cfg.cfg_ready;

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            assign w_wr[g] = w_hs & ~cfg.cfg_sync & (cfg.cfg_ch == CH_W'(g));

            clken_nco_ch #(
                .ACC_W (ACC_W)
            ) u_ch (
                .clock    (clock),
                .resetn   (resetn),
                .i_sync   (w_hs & cfg.cfg_sync),
                .i_wr     (w_wr[g]),
                .i_wr_inc (cfg.cfg_inc),
                .o_en     (en_out[g]),
                .o_pend   (pend[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clken_nco.sv
`default_nettype none
// ============================================================================
// Module      : tb_clken_nco
// Description : Randomized and directed scoreboard bench for clken_nco.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clken_nco;
    import clken_pkg::*;

    localparam int NCH   = 4;
    localparam int ACC_W = 8;
    localparam int CH_W  = 3;
    localparam int MOD   = 1 << ACC_W;

    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] pend;
        logic           ready;
    } exp_t;

    logic           clock = 1'b0;
    logic           resetn;
    logic [NCH-1:0] en_out;
    logic [NCH-1:0] pend;

    clken_nco_if #(.CH_W(CH_W), .ACC_W(ACC_W)) cfg ();

    clken_nco #(.NCH(NCH), .ACC_W(ACC_W), .CH_W(CH_W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .cfg    (cfg),
        .en_out (en_out),
        .pend   (pend)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    // Reference state: numeric phase, active/pending increment, flags.
    int unsigned m_acc[NCH];
    int unsigned m_inc[NCH];
    int unsigned m_val[NCH];
    bit          m_pnd[NCH];
    bit          m_en[NCH];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("en_out", int'(en_out), int'(e.en));
                chk("pend", int'(pend), int'(e.pend));
                chk("cfg_ready", int'(cfg.cfg_ready), int'(e.ready));
            end
        end
    end

    // One clock of stimulus: drive, predict, then advance the reference model.
    task automatic cycle(input bit rn, input bit v, input bit s,
                         input bit [CH_W-1:0] ch, input bit [ACC_W-1:0] inc);
        exp_t        e;
        bit          rdy;
        bit          hs;
        int unsigned sum;
        bit          carry;
        resetn        = rn;
        cfg.cfg_valid = v;
        cfg.cfg_sync  = s;
        cfg.cfg_ch    = ch;
        cfg.cfg_inc   = inc;
        rdy = s || (int'(ch) >= NCH) || !m_pnd[ch[1:0]];
        for (int i = 0; i < NCH; i++) begin
            e.en[i]   = m_en[i];
            e.pend[i] = m_pnd[i];
        end
        e.ready = rdy;
        q.push_back(e);
        hs = v && rdy;
        for (int i = 0; i < NCH; i++) begin
            if (!rn) begin
                m_acc[i] = 0; m_inc[i] = 0; m_val[i] = 0; m_pnd[i] = 0; m_en[i] = 0;
            end else if (hs && s) begin
                m_acc[i] = 0;
                m_en[i]  = 0;
                if (m_pnd[i]) m_inc[i] = m_val[i];
                m_pnd[i] = 0;
            end else begin
                sum      = m_acc[i] + m_inc[i];
                carry    = (sum >= MOD);
                m_acc[i] = sum % MOD;
                m_en[i]  = carry;
                if (m_pnd[i] && (carry || m_inc[i] == 0)) begin
                    m_inc[i] = m_val[i];
                    m_pnd[i] = 0;
                end
                if (hs && int'(ch) == i) begin
                    m_val[i] = inc;
                    m_pnd[i] = 1;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1, 0, 0, 0, 0);
    endtask

    initial begin
        int first0, first2, cnt;
        bit [ACC_W-1:0] rinc;
        resetn        = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_sync  = 1'b0;
        cfg.cfg_ch    = '0;
        cfg.cfg_inc   = '0;
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = 0; m_inc[i] = 0; m_val[i] = 0; m_pnd[i] = 0; m_en[i] = 0;
        end
        @(posedge clock);
        #1;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 8'd77);

        // First pulse latency from a cold channel.
        cycle(1, 1, 0, 0, ACC_W'(c_TEST_INC_QUARTER));
        first0 = 0;
        for (int n = 1; n <= 20; n++) begin
            idle(1);
            if (first0 == 0 && en_out[0]) first0 = n;
        end
        chk("first_pulse_ch0", first0, 5);

        // Rate change on ch1 plus blocked second write, sync/other writes meanwhile.
        cycle(1, 1, 0, 1, ACC_W'(c_TEST_INC_SLOW));
        idle(20);
        cycle(1, 1, 0, 1, ACC_W'(c_TEST_INC_HALF));
        for (int k = 0; k < 4; k++) cycle(1, 1, 0, 1, 8'd16);
        cycle(1, 1, 0, 2, 8'd9);
        for (int k = 0; k < 8; k++) cycle(1, 1, 0, 1, 8'd16);
        idle(20);

        // Sync alignment: ch0 inc=3 and ch2 inc=5 restart from zero phase.
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, ACC_W'(c_TEST_INC_3));
        cycle(1, 1, 0, 2, ACC_W'(c_TEST_INC_5));
        idle(30);
        cycle(1, 1, 1, 0, 0);
        chk("sync_cycle_en", int'(en_out), 0);
        first0 = 0;
        first2 = 0;
        for (int n = 1; n <= 120; n++) begin
            idle(1);
            if (first0 == 0 && en_out[0]) first0 = n;
            if (first2 == 0 && en_out[2]) first2 = n;
        end
        chk("sync_first_ch0", first0, 86);
        chk("sync_first_ch2", first2, 52);

        // Maximum increment and out-of-range channel write.
        cycle(1, 1, 0, 3, ACC_W'(c_TEST_INC_MAX));
        idle(1);
        cnt = 0;
        for (int n = 0; n < 256; n++) begin
            idle(1);
            if (en_out[3]) cnt++;
        end
        chk("max_inc_pulses", cnt, 255);
        cycle(1, 1, 0, 7, 8'd200);
        idle(10);

        // Reset while ch0 holds a pending value mid-period.
        cycle(1, 1, 0, 0, ACC_W'(c_TEST_INC_QUARTER));
        idle(3);
        cycle(1, 1, 0, 0, 8'd16);
        cycle(0, 0, 0, 0, 0);
        chk("reset_pend", int'(pend), 0);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            idle(1);
            if (en_out != '0) cnt++;
        end
        chk("silent_after_reset", cnt, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 3))
                0:       rinc = '0;
                1:       rinc = 8'd255;
                2:       rinc = 8'($urandom_range(1, 16));
                default: rinc = 8'($urandom);
            endcase
            cycle($urandom_range(0, 299) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 23) == 0, 3'($urandom_range(0, 7)), rinc);
        end

        idle(2);
        @(negedge clock);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
